// File: rtl/imm_gen_stage_pkg.sv
// Shared encodings for the immediate generator stage: RV opcodes, format tags,
// funct3/funct6 codes used by the shift and CSR-immediate decoders.
package imm_gen_stage_pkg;

    // Major opcodes (inst[6:0])
    localparam logic [6:0] OPC_LOAD      = 7'b0000011;
    localparam logic [6:0] OPC_MISC_MEM  = 7'b0001111;
    localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
    localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OPC_STORE     = 7'b0100011;
    localparam logic [6:0] OPC_OP        = 7'b0110011;
    localparam logic [6:0] OPC_LUI       = 7'b0110111;
    localparam logic [6:0] OPC_OP_32     = 7'b0111011;
    localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
    localparam logic [6:0] OPC_JALR      = 7'b1100111;
    localparam logic [6:0] OPC_JAL       = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;

    // funct3 codes
    localparam logic [2:0] F3_ADD    = 3'b000;
    localparam logic [2:0] F3_SLL    = 3'b001;
    localparam logic [2:0] F3_SRL    = 3'b101;
    localparam logic [2:0] F3_CSRRWI = 3'b101;
    localparam logic [2:0] F3_CSRRSI = 3'b110;
    localparam logic [2:0] F3_CSRRCI = 3'b111;

    // inst[31:26] patterns allowed on immediate shifts
    localparam logic [5:0] FUNCT6_ZERO = 6'b000000;
    localparam logic [5:0] FUNCT6_SRA  = 6'b010000;

    // Format tag carried alongside the immediate
    typedef enum logic [2:0] {
        FMT_NONE  = 3'd0,
        FMT_I     = 3'd1,
        FMT_S     = 3'd2,
        FMT_B     = 3'd3,
        FMT_U     = 3'd4,
        FMT_J     = 3'd5,
        FMT_SHIFT = 3'd6,
        FMT_CSRI  = 3'd7
    } imm_fmt_e;

    function automatic logic is_shift_f3(input logic [2:0] f3);
        return (f3 == F3_SLL) || (f3 == F3_SRL);
    endfunction

    function automatic logic is_csri_f3(input logic [2:0] f3);
        return (f3 == F3_CSRRWI) || (f3 == F3_CSRRSI) || (f3 == F3_CSRRCI);
    endfunction

endpackage

// File: rtl/imm_gen_stage_if.sv
// Bus between fetch (master) and the immediate generator stage (slave).
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high; the sender holds valid and payload steady until that edge, and ready
// never depends combinationally on valid. flush is a one-cycle redirect pulse.
interface imm_gen_stage_if #(
    parameter int XLEN = 32
);
    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_inst;
    logic [XLEN-1:0] in_pc;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_imm;
    logic [2:0]      out_fmt;
    logic            out_illegal;
    logic [XLEN-1:0] out_pc;

    modport master (
        output flush, in_valid, in_inst, in_pc, out_ready,
        input  in_ready, out_valid, out_imm, out_fmt, out_illegal, out_pc
    );

    modport slave (
        input  flush, in_valid, in_inst, in_pc, out_ready,
        output in_ready, out_valid, out_imm, out_fmt, out_illegal, out_pc
    );
endinterface

// File: rtl/imm_gen_stage_skid.sv
// Generic 2-entry valid/ready buffer: a main (output) register plus a skid
// register. in_ready is a flop (!skid_valid) so there is no combinational path
// from out_ready back to in_ready. flush drops both entries and any input.
module skid_buffer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);
    logic         main_valid_q, main_valid_d;
    logic         skid_valid_q, skid_valid_d;
    logic [W-1:0] main_data_q, main_data_d;
    logic [W-1:0] skid_data_q, skid_data_d;
    logic         in_fire;
    logic         main_free;

    assign in_ready  = !skid_valid_q;
    assign in_fire   = in_valid && in_ready;
    assign main_free = !main_valid_q || out_ready;
    assign out_valid = main_valid_q;
    assign out_data  = main_data_q;

    // Next-state: main refills from skid first (FIFO order), otherwise from input;
    // a held main diverts an accepted input into the skid.
    always_comb begin
        main_valid_d = main_valid_q;
        main_data_d  = main_data_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        if (flush) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (main_free) begin
            if (skid_valid_q) begin
                // in_ready is low here, so no input can be accepted this cycle
                main_valid_d = 1'b1;
                main_data_d  = skid_data_q;
                skid_valid_d = 1'b0;
            end else begin
                main_valid_d = in_fire;
                if (in_fire) begin
                    main_data_d = in_data;
                end
            end
        end else if (in_fire) begin
            skid_valid_d = 1'b1;
            skid_data_d  = in_data;
        end
    end

    // State registers; data clears on reset so outputs show reset values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
            main_data_q  <= '0;
            skid_data_q  <= '0;
        end else begin
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
            main_data_q  <= main_data_d;
            skid_data_q  <= skid_data_d;
        end
    end
endmodule

// File: rtl/imm_gen_stage.sv
// Registered RV32I/RV64I immediate generator: combinational decode of in_inst
// into {illegal, fmt, pc, imm}, captured by a 2-entry skid buffer.
module imm_gen_stage
    import imm_gen_stage_pkg::*;
#(
    parameter int XLEN = 32
) (
    input logic           clk,
    input logic           rst_n,
    imm_gen_stage_if.slave io
);
    generate
        if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
            $error("imm_gen_stage: XLEN must be 32 or 64");
        end
    endgenerate

    localparam int PW = 1 + 3 + 2 * XLEN;

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [5:0]      funct6;
    logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic [XLEN-1:0] imm_shamt, imm_shamt_w, imm_zimm;
    logic            shift_ok;
    logic [XLEN-1:0] dec_imm;
    imm_fmt_e        dec_fmt;
    logic            dec_ill;
    logic [PW-1:0]   in_payload, out_payload;

    assign opcode = io.in_inst[6:0];
    assign funct3 = io.in_inst[14:12];
    assign funct6 = io.in_inst[31:26];

    // Raw immediates for every format; the decoder below selects one.
    assign imm_i = XLEN'($signed(io.in_inst[31:20]));
    assign imm_s = XLEN'($signed({io.in_inst[31:25], io.in_inst[11:7]}));
    assign imm_b = XLEN'($signed({io.in_inst[31], io.in_inst[7], io.in_inst[30:25],
                                  io.in_inst[11:8], 1'b0}));
    assign imm_u = XLEN'($signed({io.in_inst[31:12], 12'b0}));
    assign imm_j = XLEN'($signed({io.in_inst[31], io.in_inst[19:12], io.in_inst[20],
                                  io.in_inst[30:21], 1'b0}));
    assign imm_shamt   = (XLEN == 64) ? XLEN'(io.in_inst[25:20]) : XLEN'(io.in_inst[24:20]);
    assign imm_shamt_w = XLEN'(io.in_inst[24:20]);
    assign imm_zimm    = XLEN'(io.in_inst[19:15]);

    // SLLI needs a zero upper field; SRLI/SRAI allow zero or the SRA pattern.
    // On RV32 inst[25] would be a sixth shamt bit, which does not exist.
    assign shift_ok = ((funct3 == F3_SLL) ? (funct6 == FUNCT6_ZERO)
                                          : (funct6 == FUNCT6_ZERO || funct6 == FUNCT6_SRA))
                      && !(XLEN == 32 && io.in_inst[25]);

    // Format decode; an illegal result always forces imm=0 and FMT_NONE.
    always_comb begin
        dec_imm = '0;
        dec_fmt = FMT_NONE;
        dec_ill = 1'b0;
        if (io.in_inst[1:0] != 2'b11) begin
            dec_ill = 1'b1;
        end else begin
            case (opcode)
                OPC_LOAD, OPC_JALR: begin
                    dec_fmt = FMT_I;
                    dec_imm = imm_i;
                end
                OPC_OP_IMM: begin
                    if (is_shift_f3(funct3)) begin
                        dec_fmt = FMT_SHIFT;
                        dec_imm = imm_shamt;
                        dec_ill = !shift_ok;
                    end else begin
                        dec_fmt = FMT_I;
                        dec_imm = imm_i;
                    end
                end
                OPC_OP_IMM_32: begin
                    if (XLEN == 32) begin
                        dec_ill = 1'b1;
                    end else if (funct3 == F3_ADD) begin
                        dec_fmt = FMT_I;
                        dec_imm = imm_i;
                    end else if (is_shift_f3(funct3)) begin
                        dec_fmt = FMT_SHIFT;
                        dec_imm = imm_shamt_w;
                        dec_ill = io.in_inst[25];
                    end else begin
                        dec_ill = 1'b1;
                    end
                end
                OPC_STORE: begin
                    dec_fmt = FMT_S;
                    dec_imm = imm_s;
                end
                OPC_BRANCH: begin
                    dec_fmt = FMT_B;
                    dec_imm = imm_b;
                end
                OPC_LUI, OPC_AUIPC: begin
                    dec_fmt = FMT_U;
                    dec_imm = imm_u;
                end
                OPC_JAL: begin
                    dec_fmt = FMT_J;
                    dec_imm = imm_j;
                end
                OPC_SYSTEM: begin
                    if (is_csri_f3(funct3)) begin
                        dec_fmt = FMT_CSRI;
                        dec_imm = imm_zimm;
                    end
                end
                OPC_OP, OPC_MISC_MEM: begin
                    dec_fmt = FMT_NONE;
                end
                OPC_OP_32: begin
                    dec_ill = (XLEN == 32);
                end
                default: begin
                    dec_ill = 1'b1;
                end
            endcase
        end
        if (dec_ill) begin
            dec_imm = '0;
            dec_fmt = FMT_NONE;
        end
    end

    assign in_payload = {dec_ill, dec_fmt, io.in_pc, dec_imm};

    skid_buffer #(.W(PW)) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (io.flush),
        .in_valid  (io.in_valid),
        .in_ready  (io.in_ready),
        .in_data   (in_payload),
        .out_valid (io.out_valid),
        .out_ready (io.out_ready),
        .out_data  (out_payload)
    );

    assign io.out_imm     = out_payload[XLEN-1:0];
    assign io.out_pc      = out_payload[2*XLEN-1:XLEN];
    assign io.out_fmt     = out_payload[2*XLEN+2:2*XLEN];
    assign io.out_illegal = out_payload[PW-1];
endmodule

// File: tb/tb_imm_gen_stage.sv
// Bench for imm_gen_stage: XLEN=32 instance checked through an expected queue,
// XLEN=64 instance checked directly against constant vectors.
module tb_imm_gen_stage;
    import imm_gen_stage_pkg::*;

    localparam int W32 = 1 + 3 + 32 + 32;

    typedef struct {
        logic [31:0] inst;
        logic [63:0] imm;
        logic [2:0]  fmt;
        logic        ill;
    } vec_t;

    logic clk;
    logic rst_n;
    int   checks   = 0;
    int   failures = 0;
    logic [W32-1:0] exp_q[$];
    vec_t tab32[15];
    vec_t tab64[6];

    imm_gen_stage_if #(.XLEN(32)) bus32();
    imm_gen_stage_if #(.XLEN(64)) bus64();

    imm_gen_stage #(.XLEN(32)) dut32 (.clk(clk), .rst_n(rst_n), .io(bus32));
    imm_gen_stage #(.XLEN(64)) dut64 (.clk(clk), .rst_n(rst_n), .io(bus64));

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard / monitor (XLEN=32) ----------------
    logic           prev_stall = 1'b0;
    logic [W32-1:0] prev_out   = '0;

    always @(negedge clk) begin
        logic [W32-1:0] got;
        logic [W32-1:0] exp;
        got = {bus32.out_illegal, bus32.out_fmt, bus32.out_pc, bus32.out_imm};
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall && bus32.out_valid) begin
                checks++;
                if (got !== prev_out) begin
                    failures++;
                    $display("FAIL stall_stable got=%h exp=%h", got, prev_out);
                end
            end
            if (bus32.out_valid && bus32.out_ready && !bus32.flush) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL sb_unexpected got=%h exp=none", got);
                end else begin
                    exp = exp_q.pop_front();
                    if (got !== exp) begin
                        failures++;
                        $display("FAIL sb_data got=%h exp=%h", got, exp);
                    end
                end
            end
            prev_stall = bus32.out_valid && !bus32.out_ready && !bus32.flush;
            prev_out   = got;
        end
    end

    // ---------------- driver tasks ----------------
    function automatic logic [W32-1:0] exp32(input vec_t v, input logic [31:0] pc);
        return {v.ill, v.fmt, pc, v.imm[31:0]};
    endfunction

    // Called at posedge+1; returns at posedge+1 after the transfer edge.
    task automatic send32(input vec_t v, input logic [31:0] pc);
        int n = 0;
        bus32.in_valid = 1'b1;
        bus32.in_inst  = v.inst;
        bus32.in_pc    = pc;
        while (1) begin
            @(negedge clk);
            if (bus32.in_ready) begin
                exp_q.push_back(exp32(v, pc));
                @(posedge clk); #1;
                break;
            end
            @(posedge clk); #1;
            n++;
            if (n > 200) begin
                checks++;
                failures++;
                $display("FAIL send_timeout in_ready=%b exp=1", bus32.in_ready);
                break;
            end
        end
        bus32.in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain_left got=%0d exp=0", exp_q.size());
        end
    endtask

    task automatic init_tables();
        tab32[0]  = '{32'hFFF00093, 64'hFFFFFFFF, FMT_I,     1'b0}; // ADDI -1
        tab32[1]  = '{32'hFE000EE3, 64'hFFFFFFFC, FMT_B,     1'b0}; // BEQ -4
        tab32[2]  = '{32'hFE112E23, 64'hFFFFFFFC, FMT_S,     1'b0}; // SW -4
        tab32[3]  = '{32'h4030D093, 64'h3,        FMT_SHIFT, 1'b0}; // SRAI 3
        tab32[4]  = '{32'h4230D093, 64'h0,        FMT_NONE,  1'b1}; // SRAI inst[25]=1
        tab32[5]  = '{32'h12345037, 64'h12345000, FMT_U,     1'b0}; // LUI
        tab32[6]  = '{32'h008000EF, 64'h8,        FMT_J,     1'b0}; // JAL +8
        tab32[7]  = '{32'h0002D073, 64'h5,        FMT_CSRI,  1'b0}; // CSRRWI zimm 5
        tab32[8]  = '{32'h00000033, 64'h0,        FMT_NONE,  1'b0}; // ADD
        tab32[9]  = '{32'h00000073, 64'h0,        FMT_NONE,  1'b0}; // ECALL
        tab32[10] = '{32'h0000003B, 64'h0,        FMT_NONE,  1'b1}; // OP-32 on RV32
        tab32[11] = '{32'h00000001, 64'h0,        FMT_NONE,  1'b1}; // compressed
        tab32[12] = '{32'h0010009B, 64'h0,        FMT_NONE,  1'b1}; // ADDIW on RV32
        tab32[13] = '{32'h40009093, 64'h0,        FMT_NONE,  1'b1}; // SLLI funct6=010000
        tab32[14] = '{32'h80002003, 64'hFFFFF800, FMT_I,     1'b0}; // LW -2048
        tab64[0]  = '{32'h800000B7, 64'hFFFFFFFF80000000, FMT_U,     1'b0}; // LUI
        tab64[1]  = '{32'h03F09093, 64'd63,               FMT_SHIFT, 1'b0}; // SLLI 63
        tab64[2]  = '{32'hFFF0009B, 64'hFFFFFFFFFFFFFFFF, FMT_I,     1'b0}; // ADDIW -1
        tab64[3]  = '{32'h0200909B, 64'h0,                FMT_NONE,  1'b1}; // SLLIW inst[25]=1
        tab64[4]  = '{32'h0000003B, 64'h0,                FMT_NONE,  1'b0}; // ADDW
        tab64[5]  = '{32'h4300D093, 64'd48,               FMT_SHIFT, 1'b0}; // SRAI 48
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        bus32.flush = 1'b0; bus32.in_valid = 1'b0; bus32.in_inst = '0;
        bus32.in_pc = '0;   bus32.out_ready = 1'b0;
        bus64.flush = 1'b0; bus64.in_valid = 1'b0; bus64.in_inst = '0;
        bus64.in_pc = '0;   bus64.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        checks++; if (bus32.out_valid !== 1'b0) begin failures++; $display("FAIL rst_out_valid got=%b exp=0", bus32.out_valid); end
        checks++; if (bus32.in_ready !== 1'b1) begin failures++; $display("FAIL rst_in_ready got=%b exp=1", bus32.in_ready); end
        checks++; if (bus32.out_imm !== 32'h0) begin failures++; $display("FAIL rst_out_imm got=%h exp=0", bus32.out_imm); end
        checks++; if (bus32.out_fmt !== FMT_NONE) begin failures++; $display("FAIL rst_out_fmt got=%0d exp=0", bus32.out_fmt); end
        checks++; if (bus32.out_illegal !== 1'b0) begin failures++; $display("FAIL rst_out_illegal got=%b exp=0", bus32.out_illegal); end
        checks++; if (bus32.out_pc !== 32'h0) begin failures++; $display("FAIL rst_out_pc got=%h exp=0", bus32.out_pc); end
        checks++; if (bus64.out_valid !== 1'b0) begin failures++; $display("FAIL rst64_out_valid got=%b exp=0", bus64.out_valid); end
        checks++; if (bus64.in_ready !== 1'b1) begin failures++; $display("FAIL rst64_in_ready got=%b exp=1", bus64.in_ready); end
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        bus32.out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            send32(tab32[i], 32'h1000 + 32'(i * 4));
            @(negedge clk);
            checks++; if (bus32.out_valid !== 1'b1) begin failures++; $display("FAIL basic_valid[%0d] got=%b exp=1", i, bus32.out_valid); end
            checks++; if (bus32.out_imm !== tab32[i].imm[31:0]) begin failures++; $display("FAIL basic_imm[%0d] got=%h exp=%h", i, bus32.out_imm, tab32[i].imm[31:0]); end
            checks++; if (bus32.out_fmt !== tab32[i].fmt) begin failures++; $display("FAIL basic_fmt[%0d] got=%0d exp=%0d", i, bus32.out_fmt, tab32[i].fmt); end
            checks++; if (bus32.out_illegal !== tab32[i].ill) begin failures++; $display("FAIL basic_ill[%0d] got=%b exp=%b", i, bus32.out_illegal, tab32[i].ill); end
            checks++; if (bus32.out_pc !== 32'h1000 + 32'(i * 4)) begin failures++; $display("FAIL basic_pc[%0d] got=%h", i, bus32.out_pc); end
            @(posedge clk); #1;
        end
        wait_drain();
    endtask

    task automatic test_random();
        bit drv_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 40; i++) begin
                    send32(tab32[$urandom_range(0, 14)], $urandom);
                    if ($urandom_range(0, 3) == 0) begin
                        @(posedge clk); #1;
                    end
                end
                drv_done = 1'b1;
            end
            begin
                while (!drv_done) begin
                    @(posedge clk); #1;
                    bus32.out_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        bus32.out_ready = 1'b1;
        wait_drain();
    endtask

    task automatic test_back_to_back();
        bus32.out_ready = 1'b0;
        fork
            begin
                send32(tab32[0], 32'hA000);
                send32(tab32[5], 32'hA004);
                send32(tab32[6], 32'hA008);
            end
            begin
                @(posedge clk); #2;
                checks++; if (bus32.out_valid !== 1'b1) begin failures++; $display("FAIL b2b_first_valid got=%b exp=1", bus32.out_valid); end
                checks++; if (bus32.in_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready_one got=%b exp=1", bus32.in_ready); end
                @(posedge clk); #2;
                checks++; if (bus32.in_ready !== 1'b0) begin failures++; $display("FAIL b2b_ready_full got=%b exp=0", bus32.in_ready); end
                @(posedge clk); #2;
                checks++; if (bus32.in_ready !== 1'b0) begin failures++; $display("FAIL b2b_ready_held got=%b exp=0", bus32.in_ready); end
                checks++; if (bus32.out_pc !== 32'hA000) begin failures++; $display("FAIL b2b_head_pc got=%h exp=a000", bus32.out_pc); end
                bus32.out_ready = 1'b1;
            end
        join
        wait_drain();
    endtask

    task automatic test_flush();
        bus32.out_ready = 1'b0;
        send32(tab32[1], 32'hB000);
        send32(tab32[2], 32'hB004);
        checks++; if (bus32.in_ready !== 1'b0) begin failures++; $display("FAIL flush_pre_full got=%b exp=0", bus32.in_ready); end
        bus32.in_valid = 1'b1;
        bus32.in_inst  = tab32[7].inst;
        bus32.in_pc    = 32'hDEAD;
        bus32.flush    = 1'b1;
        @(posedge clk); #1;
        bus32.flush    = 1'b0;
        bus32.in_valid = 1'b0;
        exp_q.delete();
        checks++; if (bus32.out_valid !== 1'b0) begin failures++; $display("FAIL flush_valid got=%b exp=0", bus32.out_valid); end
        checks++; if (bus32.in_ready !== 1'b1) begin failures++; $display("FAIL flush_ready got=%b exp=1", bus32.in_ready); end
        bus32.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++; if (bus32.out_valid !== 1'b0) begin failures++; $display("FAIL flush_ghost[%0d] got=%b exp=0", i, bus32.out_valid); end
        end
        @(posedge clk); #1;
        send32(tab32[14], 32'hB010);
        wait_drain();
    endtask

    task automatic test_xlen64();
        bus64.out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            bus64.in_valid = 1'b1;
            bus64.in_inst  = tab64[i].inst;
            bus64.in_pc    = 64'hFFFF_0000_0000_1000 + 64'(i * 4);
            @(posedge clk); #1;
            bus64.in_valid = 1'b0;
            @(negedge clk);
            checks++; if (bus64.out_valid !== 1'b1) begin failures++; $display("FAIL x64_valid[%0d] got=%b exp=1", i, bus64.out_valid); end
            checks++; if (bus64.out_imm !== tab64[i].imm) begin failures++; $display("FAIL x64_imm[%0d] got=%h exp=%h", i, bus64.out_imm, tab64[i].imm); end
            checks++; if (bus64.out_fmt !== tab64[i].fmt) begin failures++; $display("FAIL x64_fmt[%0d] got=%0d exp=%0d", i, bus64.out_fmt, tab64[i].fmt); end
            checks++; if (bus64.out_illegal !== tab64[i].ill) begin failures++; $display("FAIL x64_ill[%0d] got=%b exp=%b", i, bus64.out_illegal, tab64[i].ill); end
            checks++; if (bus64.out_pc !== 64'hFFFF_0000_0000_1000 + 64'(i * 4)) begin failures++; $display("FAIL x64_pc[%0d] got=%h", i, bus64.out_pc); end
            @(posedge clk); #1;
        end
        // Stall two entries, then pull reset mid-cycle.
        bus64.out_ready = 1'b0;
        bus64.in_valid  = 1'b1;
        bus64.in_inst   = tab64[0].inst;
        bus64.in_pc     = 64'h2000;
        @(posedge clk); #1;
        bus64.in_inst   = tab64[1].inst;
        bus64.in_pc     = 64'h2004;
        @(posedge clk); #1;
        bus64.in_valid  = 1'b0;
        checks++; if (bus64.out_valid !== 1'b1) begin failures++; $display("FAIL x64_stall_valid got=%b exp=1", bus64.out_valid); end
        checks++; if (bus64.in_ready !== 1'b0) begin failures++; $display("FAIL x64_stall_full got=%b exp=0", bus64.in_ready); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (bus64.out_valid !== 1'b0) begin failures++; $display("FAIL arst_valid got=%b exp=0", bus64.out_valid); end
        checks++; if (bus64.in_ready !== 1'b1) begin failures++; $display("FAIL arst_ready got=%b exp=1", bus64.in_ready); end
        checks++; if (bus64.out_imm !== 64'h0) begin failures++; $display("FAIL arst_imm got=%h exp=0", bus64.out_imm); end
        checks++; if (bus64.out_pc !== 64'h0) begin failures++; $display("FAIL arst_pc got=%h exp=0", bus64.out_pc); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (bus64.out_valid !== 1'b0) begin failures++; $display("FAIL arst_after got=%b exp=0", bus64.out_valid); end
        @(posedge clk); #1;
    endtask

    // ---------------- sequence / report ----------------
    initial begin
        init_tables();
        test_reset();
        test_basic();
        test_random();
        test_back_to_back();
        test_flush();
        test_xlen64();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
